// File: rtl/binary_bcd_pkg.sv
// Shared widths, digit types and dabble-cell mode for the binary/BCD converter.
// A bcd3_t holds the digits with hundreds at index 2 and ones at index 0.
package binary_bcd_pkg;

    localparam int BIN_W      = 8;
    localparam int BIN_OUT_W  = 10;
    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 3;
    localparam int BCD_W      = NUM_DIGITS * DIGIT_W;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;
    typedef bcd_digit_t [NUM_DIGITS-1:0] bcd3_t;

    typedef enum logic {
        DABBLE_ADD = 1'b0,
        DABBLE_SUB = 1'b1
    } dabble_mode_e;

endpackage

// File: rtl/bcd_dabble_cell.sv
// Single-digit double-dabble adjuster: +3 when >= 5 (binary->BCD),
// -3 when >= 8 (BCD->binary).
module bcd_dabble_cell
    import binary_bcd_pkg::*;
(
    input  dabble_mode_e mode,
    input  bcd_digit_t   digit_in,
    output bcd_digit_t   digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (mode == DABBLE_ADD) begin
            if (digit_in >= 4'd5) begin
                digit_out = digit_in + 4'd3;
            end
        end else begin
            if (digit_in >= 4'd8) begin
                digit_out = digit_in - 4'd3;
            end
        end
    end

endmodule

// File: rtl/binary_bcd_converter.sv
// Bidirectional binary/BCD converter: two unrolled double-dabble chains
// feeding one registered output bank (latency 1, one conversion per cycle).
module binary_bcd_converter
    import binary_bcd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIN_W-1:0]     binary_in,
    input  logic [DIGIT_W-1:0]   hundreds_in,
    input  logic [DIGIT_W-1:0]   tens_in,
    input  logic [DIGIT_W-1:0]   ones_in,
    output logic [DIGIT_W-1:0]   hundreds_out,
    output logic [DIGIT_W-1:0]   tens_out,
    output logic [DIGIT_W-1:0]   ones_out,
    output logic [BIN_OUT_W-1:0] binary_out,
    output logic                 bcd_err
);

    // Forward chain: the binary field of the scratch is never stored; the bit
    // shifted into the BCD LSB at iteration gi is simply binary_in[BIN_W-1-gi].
    bcd3_t fwd_bcd [0:BIN_W];
    assign fwd_bcd[0] = '0;

    for (genvar gi = 0; gi < BIN_W; gi++) begin : g_fwd
        bcd3_t adj;
        for (genvar gd = 0; gd < NUM_DIGITS; gd++) begin : g_digit
            bcd_dabble_cell u_cell (
                .mode      (DABBLE_ADD),
                .digit_in  (fwd_bcd[gi][gd]),
                .digit_out (adj[gd])
            );
        end
        assign fwd_bcd[gi+1] = BCD_W'({adj, binary_in[BIN_W-1-gi]});
    end

    // Reverse chain: the bit leaving the BCD LSB at iteration gi lands at
    // binary bit gi after all shifts, so the final adjust step is never needed.
    bcd3_t                rev_bcd [0:BIN_OUT_W-1];
    logic [BIN_OUT_W-1:0] rev_bin;
    assign rev_bcd[0] = {hundreds_in, tens_in, ones_in};

    for (genvar gi = 0; gi < BIN_OUT_W; gi++) begin : g_rev
        assign rev_bin[gi] = rev_bcd[gi][0][0];
        if (gi < BIN_OUT_W - 1) begin : g_adj
            bcd3_t shifted;
            bcd3_t adj;
            assign shifted = rev_bcd[gi] >> 1;
            for (genvar gd = 0; gd < NUM_DIGITS; gd++) begin : g_digit
                bcd_dabble_cell u_cell (
                    .mode      (DABBLE_SUB),
                    .digit_in  (shifted[gd]),
                    .digit_out (adj[gd])
                );
            end
            assign rev_bcd[gi+1] = adj;
        end
    end

    logic                 bcd_err_next;
    logic [BIN_OUT_W-1:0] binary_next;

    assign bcd_err_next = (hundreds_in > 4'd9) || (tens_in > 4'd9) || (ones_in > 4'd9);
    assign binary_next  = bcd_err_next ? '0 : rev_bin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hundreds_out <= '0;
            tens_out     <= '0;
            ones_out     <= '0;
            binary_out   <= '0;
            bcd_err      <= 1'b0;
        end else begin
            hundreds_out <= fwd_bcd[BIN_W][2];
            tens_out     <= fwd_bcd[BIN_W][1];
            ones_out     <= fwd_bcd[BIN_W][0];
            binary_out   <= binary_next;
            bcd_err      <= bcd_err_next;
        end
    end

endmodule

// File: tb/tb_binary_bcd_converter.sv
// Directed and sweep bench for binary_bcd_converter; expected values are
// hand-computed tables or plain decimal arithmetic on the stimulus.
module tb_binary_bcd_converter;

    logic       clk;
    logic       rst_n;
    logic [7:0] binary_in;
    logic [3:0] hundreds_in;
    logic [3:0] tens_in;
    logic [3:0] ones_in;
    logic [3:0] hundreds_out;
    logic [3:0] tens_out;
    logic [3:0] ones_out;
    logic [9:0] binary_out;
    logic       bcd_err;

    int checks = 0;
    int errors = 0;

    binary_bcd_converter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .binary_in    (binary_in),
        .hundreds_in  (hundreds_in),
        .tens_in      (tens_in),
        .ones_in      (ones_in),
        .hundreds_out (hundreds_out),
        .tens_out     (tens_out),
        .ones_out     (ones_out),
        .binary_out   (binary_out),
        .bcd_err      (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n       = 1'b0;
        binary_in   = 8'd173;
        hundreds_in = 4'd7;
        tens_in     = 4'd12;
        ones_in     = 4'd3;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({hundreds_out, tens_out, ones_out, binary_out, bcd_err} !== 23'd0) begin
            errors++;
            $display("FAIL reset_hold: got h=%0d t=%0d o=%0d bin=%0d err=%0b, want all 0",
                     hundreds_out, tens_out, ones_out, binary_out, bcd_err);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        binary_in   = 8'd0;
        hundreds_in = 4'd0;
        tens_in     = 4'd0;
        ones_in     = 4'd0;
        @(posedge clk);
        #1;
        checks++;
        if ({hundreds_out, tens_out, ones_out, binary_out, bcd_err} !== 23'd0) begin
            errors++;
            $display("FAIL reset_first_zero: got h=%0d t=%0d o=%0d bin=%0d err=%0b, want all 0",
                     hundreds_out, tens_out, ones_out, binary_out, bcd_err);
        end
        $display("txn reset: outputs h=%0d t=%0d o=%0d bin=%0d err=%0b",
                 hundreds_out, tens_out, ones_out, binary_out, bcd_err);
    endtask

    task automatic test_forward_directed();
        logic [7:0]  vin [5]  = '{8'd9, 8'd45, 8'd99, 8'd123, 8'd255};
        logic [11:0] vexp [5] = '{12'h009, 12'h045, 12'h099, 12'h123, 12'h255};
        for (int i = 0; i < 5; i++) begin
            binary_in = vin[i];
            @(posedge clk);
            #1;
            checks++;
            if ({hundreds_out, tens_out, ones_out} !== vexp[i]) begin
                errors++;
                $display("FAIL fwd_directed: in=%0d got %h want %h",
                         vin[i], {hundreds_out, tens_out, ones_out}, vexp[i]);
            end
            $display("txn fwd: bin=%0d -> %0d,%0d,%0d", vin[i], hundreds_out, tens_out, ones_out);
        end
    endtask

    task automatic test_reverse_directed();
        logic [11:0] vin [6]  = '{12'h012, 12'h045, 12'h099, 12'h123, 12'h255, 12'h999};
        logic [9:0]  vexp [6] = '{10'd12, 10'd45, 10'd99, 10'd123, 10'd255, 10'd999};
        for (int i = 0; i < 6; i++) begin
            {hundreds_in, tens_in, ones_in} = vin[i];
            @(posedge clk);
            #1;
            checks++;
            if (binary_out !== vexp[i] || bcd_err !== 1'b0) begin
                errors++;
                $display("FAIL rev_directed: bcd=%h got bin=%0d err=%0b want bin=%0d err=0",
                         vin[i], binary_out, bcd_err, vexp[i]);
            end
            $display("txn rev: bcd=%h -> %0d err=%0b", vin[i], binary_out, bcd_err);
        end
    endtask

    task automatic test_invalid_bcd();
        logic [11:0] vin [3]  = '{12'h1A0, 12'h20F, 12'hC00};
        logic [7:0]  vbin [3] = '{8'd77, 8'd200, 8'd5};
        logic [11:0] vfwd [3] = '{12'h077, 12'h200, 12'h005};
        for (int i = 0; i < 3; i++) begin
            {hundreds_in, tens_in, ones_in} = vin[i];
            binary_in = vbin[i];
            @(posedge clk);
            #1;
            checks++;
            if (binary_out !== 10'd0 || bcd_err !== 1'b1) begin
                errors++;
                $display("FAIL invalid_bcd: bcd=%h got bin=%0d err=%0b want bin=0 err=1",
                         vin[i], binary_out, bcd_err);
            end
            checks++;
            if ({hundreds_out, tens_out, ones_out} !== vfwd[i]) begin
                errors++;
                $display("FAIL invalid_fwd_track: bin=%0d got %h want %h",
                         vbin[i], {hundreds_out, tens_out, ones_out}, vfwd[i]);
            end
            $display("txn invalid: bcd=%h bin=%0d -> bin_out=%0d err=%0b fwd=%0d,%0d,%0d",
                     vin[i], vbin[i], binary_out, bcd_err, hundreds_out, tens_out, ones_out);
        end
        {hundreds_in, tens_in, ones_in} = 12'h000;
    endtask

    task automatic test_back_to_back_forward();
        int bad = 0;
        for (int v = 0; v < 256; v++) begin
            binary_in = 8'(v);
            @(posedge clk);
            #1;
            checks++;
            if (hundreds_out !== 4'(v / 100) || tens_out !== 4'((v / 10) % 10) ||
                ones_out !== 4'(v % 10)) begin
                errors++;
                bad++;
                $display("FAIL fwd_sweep: in=%0d got %0d,%0d,%0d want %0d,%0d,%0d",
                         v, hundreds_out, tens_out, ones_out, v / 100, (v / 10) % 10, v % 10);
            end
        end
        $display("txn fwd_sweep: 256 values, %0d wrong", bad);
    endtask

    task automatic test_back_to_back_reverse();
        int bad = 0;
        for (int h = 0; h < 10; h++) begin
            for (int t = 0; t < 10; t++) begin
                for (int o = 0; o < 10; o++) begin
                    hundreds_in = 4'(h);
                    tens_in     = 4'(t);
                    ones_in     = 4'(o);
                    @(posedge clk);
                    #1;
                    checks++;
                    if (binary_out !== 10'(h * 100 + t * 10 + o) || bcd_err !== 1'b0) begin
                        errors++;
                        bad++;
                        $display("FAIL rev_sweep: bcd=%0d%0d%0d got bin=%0d err=%0b",
                                 h, t, o, binary_out, bcd_err);
                    end
                end
            end
        end
        $display("txn rev_sweep: 1000 triples, %0d wrong", bad);
    endtask

    task automatic test_reset_midstream();
        binary_in   = 8'd187;
        hundreds_in = 4'd6;
        tens_in     = 4'd4;
        ones_in     = 4'd2;
        @(posedge clk);
        #1;
        checks++;
        if ({hundreds_out, tens_out, ones_out} !== 12'h187 || binary_out !== 10'd642) begin
            errors++;
            $display("FAIL midstream_pre: got %h bin=%0d want 187 bin=642",
                     {hundreds_out, tens_out, ones_out}, binary_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({hundreds_out, tens_out, ones_out, binary_out, bcd_err} !== 23'd0) begin
            errors++;
            $display("FAIL midstream_async: got h=%0d t=%0d o=%0d bin=%0d err=%0b want all 0",
                     hundreds_out, tens_out, ones_out, binary_out, bcd_err);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        binary_in   = 8'd64;
        hundreds_in = 4'd3;
        tens_in     = 4'd0;
        ones_in     = 4'd8;
        #1;
        checks++;
        if ({hundreds_out, tens_out, ones_out, binary_out, bcd_err} !== 23'd0) begin
            errors++;
            $display("FAIL midstream_hold: got h=%0d t=%0d o=%0d bin=%0d before first edge, want 0",
                     hundreds_out, tens_out, ones_out, binary_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({hundreds_out, tens_out, ones_out} !== 12'h064 || binary_out !== 10'd308 ||
            bcd_err !== 1'b0) begin
            errors++;
            $display("FAIL midstream_post: got %h bin=%0d err=%0b want 064 bin=308 err=0",
                     {hundreds_out, tens_out, ones_out}, binary_out, bcd_err);
        end
        $display("txn reset_midstream: post-release fwd=%0d,%0d,%0d bin=%0d",
                 hundreds_out, tens_out, ones_out, binary_out);
    endtask

    initial begin
        test_reset();
        test_forward_directed();
        test_reverse_directed();
        test_invalid_bcd();
        test_back_to_back_forward();
        test_back_to_back_reverse();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
